// File: rtl/tbird_light_seq.sv
// Thunderbird-style turn/hazard/brake lamp sequencer with a seven-segment state display.
// Switch levels are synchronised through two flops. The state is decoded from them every cycle,
// and the lamp and segment outputs are registered.
// Optional feature: define TBIRD_HAZARD_EN to compile in the HAZARD state (flashing all lamps).
// Without it, hazard_req is accepted but ignored.
module tbird_light_seq #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned STEP_HZ = 2,
  parameter int unsigned LAMPS   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 left_req,
  input  logic                 right_req,
  input  logic                 hazard_req,
  input  logic                 brake,
  output logic [2*LAMPS-1:0]   leds,
  output logic [6:0]           seg
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned SW  = $clog2(LAMPS + 1);

  localparam logic [LAMPS-1:0] ONES = '1;

  localparam logic [6:0] SEG_IDLE   = 7'b0111111;
  localparam logic [6:0] SEG_LEFT   = 7'b1000111;
  localparam logic [6:0] SEG_RIGHT  = 7'b0101111;
  localparam logic [6:0] SEG_HAZARD = 7'b0001001;
  localparam logic [6:0] SEG_ERROR  = 7'b0000110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT,
    S_HAZARD,
    S_ERROR
  } state_t;

  state_t             state, nstate;
  logic [1:0]         l_sy, r_sy, b_sy;
  logic               l_s, r_s, b_s;
  logic [CW-1:0]      cnt, cnt_n;
  logic [SW-1:0]      step, step_n;
  logic               tick;
  logic [LAMPS-1:0]   lmask, rmask, bside;
  logic [2*LAMPS-1:0] leds_n;
  logic [6:0]         seg_n;

  // two-flop synchronisers for the switch levels
  always_ff @(posedge clk) begin
    if (rst) begin
      l_sy <= '0;
      r_sy <= '0;
      b_sy <= '0;
    end else begin
      l_sy <= {l_sy[0], left_req};
      r_sy <= {r_sy[0], right_req};
      b_sy <= {b_sy[0], brake};
    end
  end

  assign l_s = l_sy[1];
  assign r_s = r_sy[1];
  assign b_s = b_sy[1];

`ifdef TBIRD_HAZARD_EN
  logic [1:0] h_sy;
  logic       h_s;
  logic       phase, phase_n;

  // hazard request synchroniser
  always_ff @(posedge clk) begin
    if (rst) h_sy <= '0;
    else     h_sy <= {h_sy[0], hazard_req};
  end

  assign h_s = h_sy[1];

  // hazard flash phase, reset to on
  always_ff @(posedge clk) begin
    if (rst) phase <= 1'b1;
    else     phase <= phase_n;
  end
`else
  logic unused_hazard;
  assign unused_hazard = hazard_req;
`endif

  // state decode, counter update and registered-output values; counters and
  // outputs are derived from the incoming state so an input edge shows after 3 edges
  always_comb begin
    nstate = S_IDLE;
    if (l_s && r_s)      nstate = S_ERROR;
`ifdef TBIRD_HAZARD_EN
    else if (h_s)        nstate = S_HAZARD;
`endif
    else if (l_s)        nstate = S_LEFT;
    else if (r_s)        nstate = S_RIGHT;

    tick   = (cnt == CW'(DIV - 1));
    cnt_n  = tick ? '0 : cnt + CW'(1);
    step_n = step;
`ifdef TBIRD_HAZARD_EN
    phase_n = phase;
`endif
    if (nstate != state) begin
      cnt_n  = '0;
      step_n = '0;
`ifdef TBIRD_HAZARD_EN
      phase_n = 1'b1;
`endif
    end else if (tick) begin
      if (state == S_LEFT || state == S_RIGHT)
        step_n = (step == SW'(LAMPS)) ? '0 : step + SW'(1);
`ifdef TBIRD_HAZARD_EN
      if (state == S_HAZARD)
        phase_n = ~phase;
`endif
    end

    lmask = ~(ONES << step_n);
    rmask = ~(ONES >> step_n);
    bside = b_s ? ONES : '0;

    leds_n = '0;
    seg_n  = SEG_IDLE;
    case (nstate)
      S_IDLE:   leds_n = {bside, bside};
      S_LEFT: begin
        leds_n = {lmask, bside};
        seg_n  = SEG_LEFT;
      end
      S_RIGHT: begin
        leds_n = {bside, rmask};
        seg_n  = SEG_RIGHT;
      end
`ifdef TBIRD_HAZARD_EN
      S_HAZARD: begin
        leds_n = {(2*LAMPS){phase_n}};
        seg_n  = SEG_HAZARD;
      end
`endif
      S_ERROR:  seg_n = SEG_ERROR;
      default:  ;
    endcase
  end

  // state, prescaler, step counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      step  <= '0;
      leds  <= '0;
      seg   <= SEG_IDLE;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
      step  <= step_n;
      leds  <= leds_n;
      seg   <= seg_n;
    end
  end

endmodule

// File: tb/tb_tbird_light_seq.sv
// Bench for tbird_light_seq. It uses a timeline reference model: each switch level takes effect
// two edges after it is sampled. Lamp patterns are computed from the time spent in the current
// state.
module tb_tbird_light_seq;

  localparam int unsigned CLK_HZ  = 8;
  localparam int unsigned STEP_HZ = 1;
  localparam int unsigned LAMPS   = 3;
  localparam int unsigned DIV     = CLK_HZ / STEP_HZ;

  localparam logic [6:0] SEG_IDLE  = 7'b0111111;
  localparam logic [6:0] SEG_LEFT  = 7'b1000111;
  localparam logic [6:0] SEG_RIGHT = 7'b0101111;
  localparam logic [6:0] SEG_HAZ   = 7'b0001001;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

`ifdef TBIRD_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left_req = 1'b0, right_req = 1'b0, hazard_req = 1'b0, brake = 1'b0;
  logic [2*LAMPS-1:0] leds;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_LEFT, M_RIGHT, M_HAZ, M_ERR} mstate_t;

  logic [3:0]   hist[$];          // {brake, hazard, right, left} awaiting use
  mstate_t      m_state = M_IDLE;
  int unsigned  m_t = 0;          // edges spent in m_state since entry
  logic         m_brake = 1'b0;
  bit           m_in_rst = 1'b1;
  logic [5:0]   exp_leds;
  logic [6:0]   exp_seg;

  tbird_light_seq #(
    .CLK_HZ (CLK_HZ),
    .STEP_HZ(STEP_HZ),
    .LAMPS  (LAMPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .left_req  (left_req),
    .right_req (right_req),
    .hazard_req(hazard_req),
    .brake     (brake),
    .leds      (leds),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  function automatic mstate_t decode(logic [3:0] v);
    if (v[0] && v[1]) return M_ERR;
    if (HAZ_EN && v[2]) return M_HAZ;
    if (v[0]) return M_LEFT;
    if (v[1]) return M_RIGHT;
    return M_IDLE;
  endfunction

  // Advance one rising edge, update the reference model, settle 1 time unit.
  task automatic cyc();
    logic [3:0] used;
    mstate_t    st;
    int         k;
    bit         ph;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      hist.push_back(4'b0);
      hist.push_back(4'b0);
      m_state  = M_IDLE;
      m_t      = 0;
      m_brake  = 1'b0;
      m_in_rst = 1'b1;
    end else begin
      used = hist.pop_front();
      hist.push_back({brake, hazard_req, right_req, left_req});
      st = decode(used);
      if (st != m_state) begin
        m_state = st;
        m_t     = 0;
      end else begin
        m_t++;
      end
      m_brake  = used[3];
      m_in_rst = 1'b0;
    end
    k  = int'((m_t / DIV) % (LAMPS + 1));
    ph = (((m_t / DIV) % 2) == 0);
    exp_leds = '0;
    exp_seg  = SEG_IDLE;
    if (!m_in_rst) begin
      case (m_state)
        M_IDLE: if (m_brake) exp_leds = '1;
        M_LEFT: begin
          exp_seg = SEG_LEFT;
          for (int i = 0; i < k; i++) exp_leds[LAMPS + i] = 1'b1;
          if (m_brake) for (int i = 0; i < LAMPS; i++) exp_leds[i] = 1'b1;
        end
        M_RIGHT: begin
          exp_seg = SEG_RIGHT;
          for (int i = 0; i < k; i++) exp_leds[LAMPS - 1 - i] = 1'b1;
          if (m_brake) for (int i = 0; i < LAMPS; i++) exp_leds[LAMPS + i] = 1'b1;
        end
        M_HAZ: begin
          exp_seg  = SEG_HAZ;
          exp_leds = ph ? 6'b111111 : 6'b000000;
        end
        default: exp_seg = SEG_ERR;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      cyc();
      checks++;
      if (leds !== 6'b000000 || seg !== SEG_IDLE || leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL reset edge %0d: leds=%b seg=%b expected leds=000000 seg=%b", n, leds, seg, SEG_IDLE);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_right();
    logic [5:0] tab[5] = '{6'b000000, 6'b000100, 6'b000110, 6'b000111, 6'b000000};
    right_req = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL right model edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
      if (n >= 3 && (n - 3) % 8 == 0) begin
        checks++;
        if (leds !== tab[(n - 3) / 8] || seg !== SEG_RIGHT) begin
          errors++;
          $display("FAIL right step %0d: leds=%b seg=%b expected leds=%b seg=%b", (n - 3) / 8, leds, seg, tab[(n - 3) / 8], SEG_RIGHT);
        end
      end
    end
    right_req = 1'b0;
  endtask

  task automatic test_midswitch();
    logic [5:0] tab[4] = '{6'b000000, 6'b001000, 6'b011000, 6'b111000};
    do_reset();
    right_req = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL midswitch pre edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
    end
    checks++;
    if (leds !== 6'b000110) begin
      errors++;
      $display("FAIL midswitch right step2: leds=%b expected 000110", leds);
    end
    right_req = 1'b0;
    left_req  = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL midswitch post edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
      if (n >= 3 && (n - 3) % 8 == 0) begin
        checks++;
        if (leds !== tab[(n - 3) / 8] || seg !== SEG_LEFT) begin
          errors++;
          $display("FAIL midswitch left step %0d: leds=%b seg=%b expected leds=%b seg=%b", (n - 3) / 8, leds, seg, tab[(n - 3) / 8], SEG_LEFT);
        end
      end
    end
    left_req = 1'b0;
  endtask

  task automatic test_error();
    do_reset();
    left_req  = 1'b1;
    right_req = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL error model edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
      if (n >= 3) begin
        checks++;
        if (leds !== 6'b000000 || seg !== SEG_ERR) begin
          errors++;
          $display("FAIL error state edge %0d: leds=%b seg=%b expected leds=000000 seg=%b", n, leds, seg, SEG_ERR);
        end
      end
    end
    left_req  = 1'b0;
    right_req = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL error release edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
      if (n >= 3) begin
        checks++;
        if (seg !== SEG_IDLE) begin
          errors++;
          $display("FAIL error to idle edge %0d: seg=%b expected %b", n, seg, SEG_IDLE);
        end
      end
    end
  endtask

  task automatic test_hazard_brake();
`ifdef TBIRD_HAZARD_EN
    logic [5:0] htab[3] = '{6'b111111, 6'b000000, 6'b111111};
`else
    logic [5:0] htab[3] = '{6'b000000, 6'b000000, 6'b000000};
`endif
    logic [2:0] rtab[4] = '{3'b000, 3'b100, 3'b110, 3'b111};
    do_reset();
    hazard_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL hazard model edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
      if (n >= 3 && (n - 3) % 8 == 0) begin
        checks++;
        if (leds !== htab[(n - 3) / 8]) begin
          errors++;
          $display("FAIL hazard phase %0d: leds=%b expected %b", (n - 3) / 8, leds, htab[(n - 3) / 8]);
        end
      end
    end
    hazard_req = 1'b0;
    right_req  = 1'b1;
    brake      = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL brake model edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
      if (n >= 3) begin
        checks++;
        if (leds[5:3] !== 3'b111) begin
          errors++;
          $display("FAIL brake left side edge %0d: leds[5:3]=%b expected 111", n, leds[5:3]);
        end
      end
      if (n >= 3 && n <= 27 && (n - 3) % 8 == 0) begin
        checks++;
        if (leds[2:0] !== rtab[(n - 3) / 8]) begin
          errors++;
          $display("FAIL brake right step %0d: leds[2:0]=%b expected %b", (n - 3) / 8, leds[2:0], rtab[(n - 3) / 8]);
        end
      end
    end
    right_req = 1'b0;
    brake     = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    left_req = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL resetmid pre edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (leds !== 6'b000000 || seg !== SEG_IDLE) begin
      errors++;
      $display("FAIL resetmid forced: leds=%b seg=%b expected leds=000000 seg=%b", leds, seg, SEG_IDLE);
    end
    rst = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      cyc();
      checks++;
      if (leds !== exp_leds || seg !== exp_seg) begin
        errors++;
        $display("FAIL resetmid post edge %0d: leds=%b seg=%b expected leds=%b seg=%b", n, leds, seg, exp_leds, exp_seg);
      end
      if (n == 3 || n == 11) begin
        checks++;
        if (leds !== ((n == 3) ? 6'b000000 : 6'b001000) || seg !== SEG_LEFT) begin
          errors++;
          $display("FAIL resetmid restart edge %0d: leds=%b seg=%b", n, leds, seg);
        end
      end
    end
    left_req = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] v;
    int         len;
    for (int s = 0; s < 80; s++) begin
      v   = 4'($urandom_range(0, 15));
      len = int'($urandom_range(1, 30));
      rst = ($urandom_range(0, 19) == 0);
      {brake, hazard_req, right_req, left_req} = v;
      for (int n = 0; n < len; n++) begin
        cyc();
        if (rst && n >= 1) rst = 1'b0;
        checks++;
        if (leds !== exp_leds || seg !== exp_seg) begin
          errors++;
          $display("FAIL random seg %0d edge %0d: leds=%b seg=%b expected leds=%b seg=%b", s, n, leds, seg, exp_leds, exp_seg);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_right();
    test_midswitch();
    test_error();
    test_hazard_brake();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
